// File: rtl/vend_dispenser.sv
// Vend dispenser: queues soda/change requests and sequences the soda and nickel ejectors.
// Optional per-handshake totals are enabled by defining VEND_DISPENSER_STATS_EN.
module vend_dispenser #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PULSE_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              soda_i,
    input  logic [2:0]                        change_i,
    output logic                              soda_eject_o,
    input  logic                              soda_done_i,
    output logic                              nickel_eject_o,
    input  logic                              nickel_done_i,
    output logic                              busy_o,
    output logic                              overflow_o,
    output logic                              fault_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_o
`ifdef VEND_DISPENSER_STATS_EN
    ,
    output logic [15:0]                       sodas_total_o,
    output logic [15:0]                       nickels_total_o
`endif
);

    // state      | meaning
    // IDLE       | waiting for a queued request; pops the head when non-empty
    // SODA_PULSE | soda solenoid driven for PULSE_CYCLES clocks
    // SODA_WAIT  | waiting for soda_done_i, bounded by TIMEOUT_CYCLES
    // COIN_PULSE | nickel ejector driven for PULSE_CYCLES clocks
    // COIN_WAIT  | waiting for nickel_done_i, bounded by TIMEOUT_CYCLES
    // FAULT      | mechanism timed out; ejectors off until reset
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SODA_PULSE = 3'd1,
        SODA_WAIT  = 3'd2,
        COIN_PULSE = 3'd3,
        COIN_WAIT  = 3'd4,
        FAULT      = 3'd5
    } state_t;

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PCNT_W = $clog2(PULSE_CYCLES + 1);
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic [3:0]        head;
    logic              push;
    logic              push_ok;
    logic              pop;
    logic              full;

    state_t            state;
    state_t            state_next;
    logic [PCNT_W-1:0] pulse_cnt;
    logic [WCNT_W-1:0] wait_cnt;
    logic [2:0]        cur_cnt;
    logic              pulse_active;
    logic              wait_active;

    assign push    = soda_i | (change_i != 3'd0);
    assign full    = (count == FULL_CNT);
    assign pop     = (state == IDLE) && (count != '0);
    // A pop in the same edge frees a slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr] <= {soda_i, change_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign pulse_active = (state == SODA_PULSE) || (state == COIN_PULSE);
    assign wait_active  = (state == SODA_WAIT) || (state == COIN_WAIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = head[3] ? SODA_PULSE : COIN_PULSE;
                end
            end
            SODA_PULSE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_next = SODA_WAIT;
                end
            end
            SODA_WAIT: begin
                if (soda_done_i) begin
                    state_next = (cur_cnt != 3'd0) ? COIN_PULSE : IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = FAULT;
                end
            end
            COIN_PULSE: begin
                if (pulse_cnt == PULSE_LAST) begin
                    state_next = COIN_WAIT;
                end
            end
            COIN_WAIT: begin
                if (nickel_done_i) begin
                    state_next = (cur_cnt == 3'd1) ? IDLE : COIN_PULSE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = FAULT;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            wait_cnt  <= '0;
            cur_cnt   <= 3'd0;
        end else begin
            state <= state_next;
            // Timers restart on every state entry, including WAIT -> PULSE re-entry.
            if (state_next != state) begin
                pulse_cnt <= '0;
                wait_cnt  <= '0;
            end else begin
                if (pulse_active && (pulse_cnt != PULSE_LAST)) begin
                    pulse_cnt <= pulse_cnt + 1'b1;
                end
                if (wait_active && (wait_cnt != WAIT_LAST)) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
            if (pop) begin
                cur_cnt <= head[2:0];
            end else if ((state == COIN_WAIT) && nickel_done_i) begin
                cur_cnt <= cur_cnt - 3'd1;
            end
        end
    end

`ifdef VEND_DISPENSER_STATS_EN
    logic [15:0] sodas_total;
    logic [15:0] nickels_total;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sodas_total   <= 16'd0;
            nickels_total <= 16'd0;
        end else begin
            if ((state == SODA_WAIT) && soda_done_i && (sodas_total != 16'hFFFF)) begin
                sodas_total <= sodas_total + 16'd1;
            end
            if ((state == COIN_WAIT) && nickel_done_i && (nickels_total != 16'hFFFF)) begin
                nickels_total <= nickels_total + 16'd1;
            end
        end
    end

    assign sodas_total_o   = sodas_total;
    assign nickels_total_o = nickels_total;
`endif

    assign soda_eject_o   = (state == SODA_PULSE);
    assign nickel_eject_o = (state == COIN_PULSE);
    assign fault_o        = (state == FAULT);
    assign busy_o         = (state != IDLE) || (count != '0);
    assign overflow_o     = overflow;
    assign pending_o      = count;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed self-checking bench for vend_dispenser (default parameters).
// Stats checks are compiled in when VEND_DISPENSER_STATS_EN is defined.
module tb_vend_dispenser;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       soda_i;
    logic [2:0] change_i;
    logic       soda_eject_o;
    logic       soda_done_i;
    logic       nickel_eject_o;
    logic       nickel_done_i;
    logic       busy_o;
    logic       overflow_o;
    logic       fault_o;
    logic [2:0] pending_o;
`ifdef VEND_DISPENSER_STATS_EN
    logic [15:0] sodas_total_o;
    logic [15:0] nickels_total_o;
`endif

    int compared   = 0;
    int mismatched = 0;

    vend_dispenser #(
        .FIFO_DEPTH     (4),
        .PULSE_CYCLES   (8),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .soda_i         (soda_i),
        .change_i       (change_i),
        .soda_eject_o   (soda_eject_o),
        .soda_done_i    (soda_done_i),
        .nickel_eject_o (nickel_eject_o),
        .nickel_done_i  (nickel_done_i),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .fault_o        (fault_o),
        .pending_o      (pending_o)
`ifdef VEND_DISPENSER_STATS_EN
        ,
        .sodas_total_o  (sodas_total_o),
        .nickels_total_o(nickels_total_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One cycle: inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni        = 1'b0;
        soda_i        = 1'b0;
        change_i      = 3'd0;
        soda_done_i   = 1'b0;
        nickel_done_i = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
    endtask

    task automatic measure_pulse(input bit nickel, output int len);
        len = 0;
        while (((nickel ? nickel_eject_o : soda_eject_o) === 1'b1) && (len < 64)) begin
            len++;
            step();
        end
    endtask

    task automatic wait_soda(input int budget, output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        while (!seen && (waited < budget)) begin
            if (soda_eject_o === 1'b1) begin
                seen = 1'b1;
            end else begin
                waited++;
                step();
            end
        end
    endtask

    // Strobe soda + 3 nickels, answer each done 3 cycles after the pulse ends.
    task automatic run_single_vend();
        int len;
        soda_i   = 1'b1;
        change_i = 3'd3;
        step();
        soda_i   = 1'b0;
        change_i = 3'd0;
        check("sv_pending_after_push", pending_o, 1);
        check("sv_soda_before_pop", soda_eject_o, 0);
        step();
        check("sv_soda_high_cycle2", soda_eject_o, 1);
        check("sv_pending_after_pop", pending_o, 0);
        measure_pulse(1'b0, len);
        check("sv_soda_pulse_len", len, 8);
        check("sv_no_nickel_in_wait", nickel_eject_o, 0);
        repeat (3) step();
        soda_done_i = 1'b1;
        step();
        soda_done_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("sv_nickel_start", nickel_eject_o, 1);
            measure_pulse(1'b1, len);
            check("sv_nickel_pulse_len", len, 8);
            repeat (3) step();
            nickel_done_i = 1'b1;
            step();
            nickel_done_i = 1'b0;
        end
        check("sv_end_busy", busy_o, 0);
        check("sv_end_pending", pending_o, 0);
        check("sv_end_nickel", nickel_eject_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  len;
        int  waited;
        int  serviced;
        int  bad;
        int  highs;
        bit  seen;
        bit  eject_seen;
        logic exp_bit;

        rst_ni        = 1'b0;
        soda_i        = 1'b0;
        change_i      = 3'd0;
        soda_done_i   = 1'b0;
        nickel_done_i = 1'b0;

        // Reset state
        do_reset();
        check("rst_soda_eject", soda_eject_o, 0);
        check("rst_nickel_eject", nickel_eject_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_fault", fault_o, 0);
        check("rst_pending", pending_o, 0);

        // Single vend with soda and three nickels
        run_single_vend();
`ifdef VEND_DISPENSER_STATS_EN
        run_single_vend();
        check("stats_sodas", sodas_total_o, 2);
        check("stats_nickels", nickels_total_o, 6);
`endif

        // Change-only request; a done during the pulse must be ignored
        change_i = 3'd1;
        step();
        change_i = 3'd0;
        step();
        check("co_no_soda", soda_eject_o, 0);
        check("co_nickel_cycle2", nickel_eject_o, 1);
        nickel_done_i = 1'b1;
        step();
        nickel_done_i = 1'b0;
        measure_pulse(1'b1, len);
        check("co_pulse_len_done_ignored", len + 1, 8);
        check("co_waiting_busy", busy_o, 1);
        nickel_done_i = 1'b1;
        step();
        nickel_done_i = 1'b0;
        check("co_done_busy", busy_o, 0);
        check("co_done_nickel", nickel_eject_o, 0);

        // Overflow: six back-to-back soda strobes, mechanism silent
        check("ovf_before", overflow_o, 0);
        for (int i = 0; i < 6; i++) begin
            soda_i = 1'b1;
            step();
        end
        soda_i = 1'b0;
        check("ovf_pending_full", pending_o, 4);
        check("ovf_sticky_set", overflow_o, 1);
        check("ovf_first_pulsing", soda_eject_o, 1);
        serviced = 0;
        for (int r = 0; r < 6; r++) begin
            wait_soda(40, seen, waited);
            if (!seen) break;
            if (r == 1) check("ovf_idle_gap", waited, 1);
            serviced++;
            measure_pulse(1'b0, len);
            soda_done_i = 1'b1;
            step();
            soda_done_i = 1'b0;
        end
        check("ovf_serviced", serviced, 5);
        check("ovf_end_busy", busy_o, 0);
        check("ovf_end_pending", pending_o, 0);
        check("ovf_still_sticky", overflow_o, 1);

        // Timeout in SODA_WAIT
        do_reset();
        check("to_overflow_cleared", overflow_o, 0);
        soda_i = 1'b1;
        step();
        soda_i = 1'b0;
        step();
        measure_pulse(1'b0, len);
        check("to_soda_len", len, 8);
        repeat (1023) step();
        check("to_fault_not_yet", fault_o, 0);
        step();
        check("to_fault_set", fault_o, 1);
        check("to_soda_off", soda_eject_o, 0);
        check("to_busy", busy_o, 1);
        soda_done_i = 1'b1;
        soda_i      = 1'b1;
        change_i    = 3'd2;
        step();
        soda_i   = 1'b0;
        change_i = 3'd0;
        check("to_pending_push", pending_o, 1);
        eject_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (soda_eject_o === 1'b1 || nickel_eject_o === 1'b1) eject_seen = 1'b1;
            step();
        end
        soda_done_i = 1'b0;
        check("to_no_eject", eject_seen, 0);
        check("to_pending_held", pending_o, 1);
        check("to_fault_sticky", fault_o, 1);

        // Held nickel_done with four nickels: 8 high, 1 wait cycle, repeated
        do_reset();
        check("hd_fault_cleared", fault_o, 0);
        nickel_done_i = 1'b1;
        change_i      = 3'd4;
        step();
        change_i = 3'd0;
        step();
        bad   = 0;
        highs = 0;
        for (int c = 2; c <= 38; c++) begin
            exp_bit = (c <= 36) && (((c - 2) % 9) < 8);
            if (nickel_eject_o !== exp_bit) bad++;
            if (nickel_eject_o === 1'b1) highs++;
            step();
        end
        nickel_done_i = 1'b0;
        check("hd_pattern_errors", bad, 0);
        check("hd_high_cycles", highs, 32);
        check("hd_end_busy", busy_o, 0);

        // Reset in the middle of a nickel pulse with requests queued
        change_i = 3'd1;
        repeat (3) step();
        change_i = 3'd0;
        check("mr_pending", pending_o, 2);
        check("mr_pulsing", nickel_eject_o, 1);
        step();
        rst_ni = 1'b0;
        step();
        check("mr_nickel", nickel_eject_o, 0);
        check("mr_soda", soda_eject_o, 0);
        check("mr_busy", busy_o, 0);
        check("mr_pending_cleared", pending_o, 0);
        check("mr_fault", fault_o, 0);
        check("mr_overflow", overflow_o, 0);
        rst_ni = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vend_dispenser.md
Name: vend_dispenser

Overview:
- Downstream stage of the coin-vending FSM. Consumes its single-cycle soda/change outputs.
- Queues each vend request in a small FIFO.
- Sequences the physical actuators: one soda-eject pulse, then N nickel-eject pulses, each closed by a done handshake from the mechanism. Includes timeout and fault detection.

Parameters:
FIFO_DEPTH, 4, number of queued vend requests (power of two, >=2)
PULSE_CYCLES, 8, width in clocks of each eject pulse (>=1)
TIMEOUT_CYCLES, 1024, max clocks to wait for a done_i after a pulse ends (>=2)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_ni  input  1  synchronous active-low reset
soda_i  input  1  one-cycle "vend a soda" strobe from vending FSM
change_i  input  3  change owed in nickels (0..7), valid in same cycle as strobe
soda_eject_o  output  1  soda solenoid drive
soda_done_i  input  1  soda-drop sensor, level or pulse
nickel_eject_o  output  1  nickel ejector drive, one pulse per nickel
nickel_done_i  input  1  nickel-drop sensor, level or pulse
busy_o  output  1  state!=IDLE or FIFO non-empty
overflow_o  output  1  sticky, request dropped because FIFO full
fault_o  output  1  sticky, mechanism timeout
pending_o  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_ni=0 at a rising edge): all outputs 0, FIFO empty, state IDLE, counters 0. Reset mid-operation aborts the pulse immediately and discards queued requests.
- Push: at any edge where soda_i | (change_i!=0), entry {soda_i, change_i} is written. Entry is 4 bits.
- Full FIFO: push is dropped and overflow_o is set, unless a pop happens at the same edge. A simultaneous push and pop is always accepted; occupancy is unchanged.
- Outputs are Moore-decoded from state, so they are glitch-free registered-state decodes.
- FSM states: IDLE, SODA_PULSE, SODA_WAIT, COIN_PULSE, COIN_WAIT, FAULT.
- IDLE:
  - If FIFO non-empty: pop into cur_soda/cur_cnt.
  - Go to SODA_PULSE if cur_soda. Otherwise go to COIN_PULSE (cnt is nonzero by the push rule).
- SODA_PULSE: soda_eject_o=1 for exactly PULSE_CYCLES clocks, then go to SODA_WAIT.
- SODA_WAIT:
  - On soda_done_i=1: go to COIN_PULSE if cur_cnt!=0, else IDLE.
  - Wait counter expires after TIMEOUT_CYCLES clocks: go to FAULT.
- COIN_PULSE: nickel_eject_o=1 for PULSE_CYCLES clocks, then go to COIN_WAIT.
- COIN_WAIT:
  - On nickel_done_i=1: decrement cur_cnt. If the result is 0 go to IDLE, else back to COIN_PULSE.
  - Timeout: go to FAULT.
- done inputs are sampled only in WAIT states. Assertion during PULSE or IDLE is ignored. A done held high across states satisfies the WAIT on its first cycle.
- FAULT:
  - Both eject outputs 0, fault_o=1.
  - No pops; pushes continue until full, with overflow rules unchanged.
  - Exit only by reset.
- Latency: with IDLE and an empty FIFO, a strobe in cycle 0 is pushed at edge 1, popped at edge 2, and the eject output is high in cycle 2.
- Back-to-back requests: the next pop occurs in the IDLE cycle after the previous request completes, giving at least 1 idle cycle between requests.
- Pulse and wait counters reset on every state entry. The pulse counter is $clog2(PULSE_CYCLES+1) bits and does not wrap.

Optional Feature:
- Macro: VEND_DISPENSER_STATS_EN.
- Defined:
  - Adds outputs sodas_total_o[15:0] and nickels_total_o[15:0].
  - Each increments on each completed done handshake (SODA_WAIT / COIN_WAIT exit by done).
  - Saturating at 16'hFFFF; reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Single vend, PULSE_CYCLES=8: soda_i=1, change_i=3'b011 in cycle 0; done responses 3 cycles after each pulse ends.
  - soda_eject_o high cycles 2-9, then 3 nickel pulses of 8 cycles.
  - Ends in IDLE with busy_o=0 and pending_o=0.
- Change-only request: change_i=3'b001, soda_i=0 → no soda pulse; exactly one nickel_eject_o pulse starting cycle 2.
- Overflow, DEPTH=4, mechanism held (no done):
  - 6 strobes on consecutive cycles → first popped, next 4 queued, 6th dropped.
  - pending_o=4 and overflow_o=1.
  - After the done responses, exactly 5 requests are serviced.
- Timeout: soda_done_i never asserted → fault_o=1 exactly TIMEOUT_CYCLES clocks after entering SODA_WAIT. Ejects stay 0; a later strobe raises pending_o but causes no pulse.
- Early/held done: nickel_done_i tied 1 with change_i=3'b100 → 4 pulses each followed by a 1-cycle WAIT. rst_ni=0 mid-pulse → next cycle all outputs 0, pending_o=0.
- With VEND_DISPENSER_STATS_EN: the first scenario repeated twice → sodas_total_o=2, nickels_total_o=6.
